mem_issue_sched: RTL and testbench
==================================

# mem_issue_sched

Memory-pipe issue scheduler between the register-read/source stage and the single data-memory request port. It accepts up to two memory-class source instructions per cycle (the two memory slots of the source bundle) into a DEPTH-entry in-order queue. It presents them one per cycle to the memory unit over a valid/ready handshake, preserving program order (slot 0 older than slot 1). It also provides back-pressure to the source stage, whole-queue flush on mispredict/exception, and a saturating stall counter.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥ 2
- CNT_W, 32, width of stall counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  discard all queued entries this cycle
- in_valid  in  2  per-slot enqueue request; bit 0 = older slot
- in_instr  in  2 × source_instr_t  per-slot instruction payload (memory slots of source_data_t)
- in_ready  out  1  queue can accept both slots this cycle
- req_valid  out  1  head entry is valid for the memory unit
- req_instr  out  source_instr_t  head entry payload
- req_ready  in  1  memory unit accepts head this cycle
- count  out  $clog2(DEPTH)+1  current occupancy
- stall_cnt  out  CNT_W  cycles with req_valid && !req_ready, saturating

## Operation
- Storage: circular buffer of DEPTH source_instr_t entries, head pointer, tail pointer and occupancy count, all registered.
- in_ready = (DEPTH − count) ≥ 2. It is computed from the registered count only, so a same-cycle dequeue does not grant credit.
- Enqueue happens only when in_ready is high. in_valid is ignored when in_ready is low; upstream holds its payload.
- Compaction, program order preserved:
  - in_valid = 11: slot 0 goes to tail, slot 1 to tail+1, tail advances by 2.
  - in_valid = 01: slot 0 goes to tail, tail advances by 1.
  - in_valid = 10: slot 1 goes to tail, tail advances by 1.
  - in_valid = 00: no change.
- The valid field inside in_instr is not consulted; in_valid alone decides enqueue. Stored entries keep the payload unmodified.
- Dequeue when req_valid && req_ready: head advances by 1.
- req_valid = (count ≠ 0). req_instr = storage[head], driven from registers with no combinational path from in_* to req_*.
- Simultaneous enqueue and dequeue: count_next = count + n_enq − deq. Pointers wrap modulo DEPTH.
- flush has priority over everything in the same cycle:
  - head, tail and count are set to 0.
  - Same-cycle enqueue is dropped; same-cycle dequeue handshake counts as not taken.
  - Storage contents need not be cleared.
- stall_cnt increments when req_valid && !req_ready and holds at 2^CNT_W − 1. It is cleared only by reset; flush does not clear it.

## Timing
- Reset values: count = 0, head = tail = 0, req_valid = 0, in_ready = 1, stall_cnt = 0. req_instr is don't-care while req_valid = 0.
- Enqueue-to-request latency is 1 cycle: an entry written at edge N is visible on req_* after edge N.
- Throughput: 1 dequeue per cycle sustained; burst enqueue of 2 per cycle while in_ready is high.
- Stability: while req_valid && !req_ready and flush = 0, req_instr and req_valid hold constant.
- Full boundary: count = DEPTH−1 forces in_ready = 0 even if a single-slot enqueue would fit.
- Empty boundary: count = 0 gives req_valid = 0, and req_ready is ignored.
- Reset asserted mid-operation overrides flush and all handshakes. All state returns to reset values at the next edge.

## Test plan
- Reset, then idle: count = 0, req_valid = 0, in_ready = 1, stall_cnt = 0 for 5 cycles.
- Ordering: with req_ready = 0, enqueue in_valid = 11 (pc A, B), then 10 (pc C). After this, count = 3 and in_ready = 0. Raise req_ready: pcs A, B, C appear on consecutive cycles, then req_valid = 0.
- Back-pressure and stall counter: fill DEPTH = 4 with req_ready = 0 and hold for 10 cycles. Required: req_instr stable, stall_cnt = 10, in_ready = 0 while count ≥ 3, and in_valid changes are ignored.
- Simultaneous enqueue/dequeue at count = 2 with in_valid = 01 and req_ready = 1: count stays 2, head advances, new entry lands at tail. Repeat 8 cycles to wrap the pointers with FIFO order intact.
- Flush with in_valid = 11, req_ready = 1 and count = 2: next cycle count = 0, req_valid = 0, in_ready = 1, and no flushed pc ever reappears on req_instr.
- Saturation with CNT_W = 4: 20 stall cycles give stall_cnt = 15. A subsequent flush leaves it at 15; reset clears it to 0.

Source files
------------

// File: rtl/mem_issue_sched.sv
// mem_issue_sched
// ---------------------------------------------------------------------------
// Memory-pipe issue scheduler. Accepts up to two memory-class instructions per
// cycle from the source stage into an in-order circular queue and presents
// them one per cycle to the data-memory request port over valid/ready.
//
// Parameters
//   DEPTH   : queue entries (power of two, >= 2)
//   CNT_W   : width of the saturating stall counter
//   INSTR_W : width of one source_instr_t payload (opaque to this block)
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-high
//   flush      : discard every queued entry this cycle (priority over all I/O)
//   in_valid   : per-slot enqueue request, bit 0 is the older slot
//   in_instr   : two payloads packed {slot1, slot0}
//   in_ready   : queue can take both slots this cycle (registered count only)
//   req_valid  : head entry valid toward the memory unit
//   req_instr  : head entry payload
//   req_ready  : memory unit accepts the head this cycle
//   count      : current occupancy
//   stall_cnt  : saturating count of cycles with req_valid && !req_ready
// ---------------------------------------------------------------------------
module mem_issue_sched #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 32,
    parameter int INSTR_W = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [1:0]                 in_valid,
    input  logic [2*INSTR_W-1:0]       in_instr,
    output logic                       in_ready,
    output logic                       req_valid,
    output logic [INSTR_W-1:0]         req_instr,
    input  logic                       req_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Queue storage and bookkeeping
    logic [INSTR_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [OCC_W-1:0]   count_reg;
    logic [CNT_W-1:0]   stall_reg;

    // Next-state values
    logic [PTR_W-1:0]   head_next;
    logic [PTR_W-1:0]   tail_next;
    logic [OCC_W-1:0]   count_next;

    // Per-cycle decode
    logic [INSTR_W-1:0] slot0_instr;
    logic [INSTR_W-1:0] slot1_instr;
    logic [INSTR_W-1:0] first_data;
    logic               wr_first_en;
    logic               wr_second_en;
    logic [OCC_W-1:0]   n_enq;
    logic               deq;
    logic [PTR_W-1:0]   tail_plus1;

    assign slot0_instr = in_instr[INSTR_W-1:0];
    assign slot1_instr = in_instr[2*INSTR_W-1:INSTR_W];

    // Credit is judged on the registered occupancy only: an entry leaving in
    // the same cycle does not make room for new ones until the next cycle.
    assign in_ready  = (count_reg <= OCC_W'(DEPTH - 2));
    assign req_valid = (count_reg != '0);
    assign req_instr = mem_reg[head_reg];
    assign count     = count_reg;
    assign stall_cnt = stall_reg;

    assign tail_plus1 = tail_reg + PTR_W'(1);

    always_comb begin
        // Compaction: the oldest valid slot always lands at tail, so a lone
        // slot-1 request is written exactly where a lone slot-0 one would be.
        wr_first_en  = in_ready && !flush && (in_valid != 2'b00);
        wr_second_en = in_ready && !flush && (in_valid == 2'b11);
        first_data   = in_valid[0] ? slot0_instr : slot1_instr;
        n_enq        = OCC_W'(wr_first_en) + OCC_W'(wr_second_en);

        // A flushed cycle treats the handshake as not taken.
        deq          = req_valid && req_ready && !flush;

        head_next    = head_reg + PTR_W'(deq);
        tail_next    = tail_reg + n_enq[PTR_W-1:0];
        count_next   = count_reg + n_enq - OCC_W'(deq);
    end

    // Payload storage has no reset: contents are meaningless until written
    // and are only ever observed at head while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr_first_en) begin
            mem_reg[tail_reg] <= first_data;
        end
        if (wr_second_en) begin
            mem_reg[tail_plus1] <= slot1_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Stall counter survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_reg <= '0;
        end else if (req_valid && !req_ready && (stall_reg != {CNT_W{1'b1}})) begin
            stall_reg <= stall_reg + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_issue_sched.sv
module tb_mem_issue_sched;

    localparam int IW = 64;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT a: DEPTH=4, CNT_W=32 ----------------
    logic          reset, flush, in_ready, req_valid, req_ready;
    logic [1:0]    in_valid;
    logic [2*IW-1:0] in_instr;
    logic [IW-1:0] req_instr;
    logic [2:0]    count;
    logic [31:0]   stall_cnt;

    mem_issue_sched #(.DEPTH(4), .CNT_W(32), .INSTR_W(IW)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .req_valid (req_valid),
        .req_instr (req_instr),
        .req_ready (req_ready),
        .count     (count),
        .stall_cnt (stall_cnt)
    );

    // ---------------- DUT b: DEPTH=4, CNT_W=4 ----------------
    logic          b_reset, b_flush, b_in_ready, b_req_valid, b_req_ready;
    logic [1:0]    b_in_valid;
    logic [2*IW-1:0] b_in_instr;
    logic [IW-1:0] b_req_instr;
    logic [2:0]    b_count;
    logic [3:0]    b_stall_cnt;

    mem_issue_sched #(.DEPTH(4), .CNT_W(4), .INSTR_W(IW)) dut_b (
        .clk       (clk),
        .reset     (b_reset),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_instr  (b_in_instr),
        .in_ready  (b_in_ready),
        .req_valid (b_req_valid),
        .req_instr (b_req_instr),
        .req_ready (b_req_ready),
        .count     (b_count),
        .stall_cnt (b_stall_cnt)
    );

    // Payload: pc in low half, complemented pc in high half.
    function automatic logic [IW-1:0] mk(input logic [31:0] pc);
        return {~pc, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %0d %s observed=%h expected=%h", checks, tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 2'b00; in_instr = '0; req_ready = 1'b0;
        b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 2'b00; b_in_instr = '0; b_req_ready = 1'b0;

        // ---------- Reset then idle ----------
        do_reset();
        b_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_count", 64'(count), 64'd0);
            check("idle_req_valid", 64'(req_valid), 64'd0);
            check("idle_in_ready", 64'(in_ready), 64'd1);
            check("idle_stall", 64'(stall_cnt), 64'd0);
        end

        // ---------- Ordering ----------
        req_ready = 1'b0;
        in_valid = 2'b11; in_instr = {mk(32'h0B), mk(32'h0A)};
        step();
        check("ord_count2", 64'(count), 64'd2);
        check("ord_in_ready2", 64'(in_ready), 64'd1);
        check("ord_head_A", req_instr, mk(32'h0A));
        in_valid = 2'b10; in_instr = {mk(32'h0C), mk(32'hDEAD)};
        step();
        in_valid = 2'b00;
        check("ord_count3", 64'(count), 64'd3);
        check("ord_in_ready3", 64'(in_ready), 64'd0);
        req_ready = 1'b1;
        check("ord_A", req_instr, mk(32'h0A));
        step();
        check("ord_B", req_instr, mk(32'h0B));
        step();
        check("ord_C", req_instr, mk(32'h0C));
        check("ord_valid_C", 64'(req_valid), 64'd1);
        step();
        check("ord_empty_valid", 64'(req_valid), 64'd0);
        check("ord_empty_count", 64'(count), 64'd0);

        // ---------- Back-pressure and stall counter ----------
        do_reset();
        req_ready = 1'b0;
        in_valid = 2'b11; in_instr = {mk(32'h101), mk(32'h100)};
        step();
        in_valid = 2'b11; in_instr = {mk(32'h103), mk(32'h102)};
        step();
        check("bp_full_count", 64'(count), 64'd4);
        check("bp_fill_stall", 64'(stall_cnt), 64'd1);
        // 9 more stalled cycles (10 stall cycles in total since head appeared)
        for (int i = 0; i < 9; i++) begin
            in_valid = 2'((i % 3) + 1);
            in_instr = {mk(32'h900 + 32'(i)), mk(32'h800 + 32'(i))};
            step();
            check("bp_hold_instr", req_instr, mk(32'h100));
            check("bp_hold_valid", 64'(req_valid), 64'd1);
            check("bp_hold_count", 64'(count), 64'd4);
            check("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        check("bp_stall10", 64'(stall_cnt), 64'd10);
        in_valid = 2'b00;
        req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_drain", req_instr, mk(32'h100 + 32'(i)));
            step();
        end
        check("bp_drained", 64'(req_valid), 64'd0);
        check("bp_stall_held", 64'(stall_cnt), 64'd10);

        // ---------- Simultaneous enqueue/dequeue with pointer wrap ----------
        do_reset();
        req_ready = 1'b0;
        in_valid = 2'b11; in_instr = {mk(32'h2001), mk(32'h2000)};
        step();
        check("sim_start_count", 64'(count), 64'd2);
        for (int i = 0; i < 8; i++) begin
            in_valid = 2'b01;
            in_instr = {mk(32'hBAD0), mk(32'h2000 + 32'(i + 2))};
            req_ready = 1'b1;
            check("sim_head", req_instr, mk(32'h2000 + 32'(i)));
            step();
            check("sim_count", 64'(count), 64'd2);
        end
        in_valid = 2'b00;
        check("sim_tail0", req_instr, mk(32'h2008));
        step();
        check("sim_tail1", req_instr, mk(32'h2009));
        step();
        check("sim_empty", 64'(req_valid), 64'd0);

        // ---------- Flush ----------
        do_reset();
        req_ready = 1'b0;
        in_valid = 2'b11; in_instr = {mk(32'h3001), mk(32'h3000)};
        step();
        check("fl_pre_count", 64'(count), 64'd2);
        flush = 1'b1; req_ready = 1'b1;
        in_valid = 2'b11; in_instr = {mk(32'h3F01), mk(32'h3F00)};
        step();
        flush = 1'b0; in_valid = 2'b00;
        check("fl_count", 64'(count), 64'd0);
        check("fl_req_valid", 64'(req_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        step();
        check("fl_still_empty", 64'(req_valid), 64'd0);
        in_valid = 2'b01; in_instr = {mk(32'hBAD1), mk(32'h3100)};
        req_ready = 1'b0;
        step();
        in_valid = 2'b00;
        check("fl_new_head", req_instr, mk(32'h3100));
        check("fl_new_count", 64'(count), 64'd1);
        req_ready = 1'b1;
        step();
        check("fl_no_ghost", 64'(req_valid), 64'd0);

        // ---------- Saturation (CNT_W = 4) ----------
        b_req_ready = 1'b0;
        b_in_valid = 2'b11; b_in_instr = {mk(32'h4001), mk(32'h4000)};
        step();
        b_in_valid = 2'b00;
        check("sat_start", 64'(b_stall_cnt), 64'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 13) check("sat_14", 64'(b_stall_cnt), 64'd14);
            if (i == 14) check("sat_15", 64'(b_stall_cnt), 64'd15);
        end
        check("sat_20", 64'(b_stall_cnt), 64'd15);
        b_flush = 1'b1;
        step();
        b_flush = 1'b0;
        check("sat_flush_count", 64'(b_count), 64'd0);
        check("sat_flush_keep", 64'(b_stall_cnt), 64'd15);
        step();
        check("sat_after_flush", 64'(b_stall_cnt), 64'd15);
        // Refill, then reset together with flush and enqueue: reset wins.
        b_in_valid = 2'b11; b_in_instr = {mk(32'h4101), mk(32'h4100)};
        step();
        b_reset = 1'b1; b_flush = 1'b1;
        step();
        b_reset = 1'b0; b_flush = 1'b0; b_in_valid = 2'b00;
        check("sat_reset_stall", 64'(b_stall_cnt), 64'd0);
        check("sat_reset_count", 64'(b_count), 64'd0);
        check("sat_reset_valid", 64'(b_req_valid), 64'd0);
        check("sat_reset_in_ready", 64'(b_in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
